// File: rtl/inst_fetch_resp_if.sv
// Fetch-side bus between the PC stage (master) and the instruction
// responder (slave), including the program-store load port.
interface inst_fetch_resp_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  ce;
  logic [31:0]           pc;
  logic                  stallreq;
  logic [31:0]           inst;
  logic                  inst_valid;
  logic                  inst_err;
  logic                  prog_we;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [31:0]           prog_wdata;
  logic [31:0]           fetch_count;

  modport master (
    output ce, pc, prog_we, prog_addr, prog_wdata,
    input  stallreq, inst, inst_valid, inst_err, fetch_count
  );

  modport slave (
    input  ce, pc, prog_we, prog_addr, prog_wdata,
    output stallreq, inst, inst_valid, inst_err, fetch_count
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: word-addressed program store with a
// programmable number of wait states per fetch and a stall request back
// to the PC stage while a fetch is outstanding.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no fetch outstanding; zero-wait fetches accepted directly
// S_WAIT | fetch latched in r_req_addr, counting down wait states
module inst_fetch_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_resp_if.slave  bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam bit         LP_HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [3:0] LP_CNT_INIT = LP_HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_req_addr;
  logic [31:0]           r_inst;
  logic                  r_inst_valid;
  logic                  r_inst_err;
  logic [31:0]           r_fetch_count;
  logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                  w_stallreq;
  logic                  w_accept;
  logic [31:0]           w_fetch_addr;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_err;

  // Stall is held off during reset; no path from pc reaches it.
  always_comb begin
    w_stallreq = 1'b0;
    if (rst && bus.ce) begin
      if (r_state == S_IDLE) w_stallreq = LP_HAS_WAIT;
      else                   w_stallreq = (r_cnt != 4'd0);
    end
  end

  // Once in S_WAIT the latched address is used, not the live pc.
  always_comb begin
    w_accept     = bus.ce & ~w_stallreq & rst;
    w_fetch_addr = (r_state == S_WAIT) ? r_req_addr : bus.pc;
    w_index      = w_fetch_addr[ADDR_WIDTH+1:2];
    w_err        = (w_fetch_addr[1:0] != 2'b00) ||
                   (w_fetch_addr[31:ADDR_WIDTH+2] != '0);
  end

  // Program-store load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && bus.prog_we) r_mem[bus.prog_addr] <= bus.prog_wdata;
  end

  // Fetch FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_req_addr    <= 32'h0;
      r_inst        <= 32'h0;
      r_inst_valid  <= 1'b0;
      r_inst_err    <= 1'b0;
      r_fetch_count <= 32'h0;
    end else begin
      r_inst_valid <= w_accept;
      r_inst_err   <= w_accept & w_err;
      if (w_accept) begin
        r_inst        <= w_err ? 32'h0 : r_mem[w_index];
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.ce && LP_HAS_WAIT) begin
            r_req_addr <= bus.pc;
            r_cnt      <= LP_CNT_INIT;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Dropping ce abandons the fetch without a response.
          if (!bus.ce)               r_state <= S_IDLE;
          else if (r_cnt != 4'd0)    r_cnt   <= r_cnt - 4'd1;
          else                       r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stallreq    = w_stallreq;
  assign bus.inst        = r_inst;
  assign bus.inst_valid  = r_inst_valid;
  assign bus.inst_err    = r_inst_err;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: three instances (0, 2 and 3 wait states)
// sharing clock, reset and program-load traffic. Expected responses are
// queued when a fetch is driven and popped when inst_valid appears.
module tb_inst_fetch_resp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_resp_if #(.ADDR_WIDTH(10)) f0 ();
  inst_fetch_resp_if #(.ADDR_WIDTH(10)) f2 ();
  inst_fetch_resp_if #(.ADDR_WIDTH(10)) f3 ();

  inst_fetch_resp #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(f0));
  inst_fetch_resp #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u2 (.clk(clk), .rst(rst), .bus(f2));
  inst_fetch_resp #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u3 (.clk(clk), .rst(rst), .bus(f3));

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] q0[$], q2[$], q3[$];
  logic [31:0] ref_mem [0:15];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // {err, data} a fetch of pc should return, from the reference store.
  function automatic logic [63:0] exp_of(input logic [31:0] pc);
    logic e;
    e = (pc[1:0] != 2'b00) || (pc[31:12] != 20'h0);
    return {31'h0, e, (e ? 32'h0 : ref_mem[pc[5:2]])};
  endfunction

  task automatic set_fetch(input int d, input logic ce, input logic [31:0] pc);
    case (d)
      0: begin f0.ce = ce; f0.pc = pc; end
      2: begin f2.ce = ce; f2.pc = pc; end
      default: begin f3.ce = ce; f3.pc = pc; end
    endcase
  endtask

  task automatic push_exp(input int d, input logic [63:0] e);
    case (d)
      0: q0.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic logic [31:0] get_fc(input int d);
    case (d)
      0: return f0.fetch_count;
      2: return f2.fetch_count;
      default: return f3.fetch_count;
    endcase
  endfunction

  function automatic logic get_stall(input int d);
    case (d)
      0: return f0.stallreq;
      2: return f2.stallreq;
      default: return f3.stallreq;
    endcase
  endfunction

  task automatic set_prog(input logic we, input logic [9:0] a, input logic [31:0] w);
    f0.prog_we = we; f0.prog_addr = a; f0.prog_wdata = w;
    f2.prog_we = we; f2.prog_addr = a; f2.prog_wdata = w;
    f3.prog_we = we; f3.prog_addr = a; f3.prog_wdata = w;
  endtask

  // Full fetch on a wait-state instance: ce held ws+1 cycles, then dropped.
  task automatic fetch_ws(input int d, input int ws, input logic [31:0] pc, input string tag);
    cyc();
    set_fetch(d, 1'b1, pc);
    push_exp(d, exp_of(pc));
    #1 chk({tag, "_stall_c0"}, 64'(get_stall(d)), 64'(ws != 0));
    for (int k = 1; k <= ws; k++) begin
      cyc();
      chk($sformatf("%s_stall_c%0d", tag, k), 64'(get_stall(d)), 64'(k != ws));
    end
    cyc();
    set_fetch(d, 1'b0, 32'h0);
  endtask

  // Response scoreboard for all three instances.
  always @(negedge clk) begin
    if (f0.inst_valid === 1'b1) begin
      if (q0.size() == 0) chk("u0_spurious_valid", 64'd1, 64'd0);
      else chk("u0_resp", {31'h0, f0.inst_err, f0.inst}, q0.pop_front());
    end
    if (f2.inst_valid === 1'b1) begin
      if (q2.size() == 0) chk("u2_spurious_valid", 64'd1, 64'd0);
      else chk("u2_resp", {31'h0, f2.inst_err, f2.inst}, q2.pop_front());
    end
    if (f3.inst_valid === 1'b1) begin
      if (q3.size() == 0) chk("u3_spurious_valid", 64'd1, 64'd0);
      else chk("u3_resp", {31'h0, f3.inst_err, f3.inst}, q3.pop_front());
    end
  end

  initial begin
    set_fetch(0, 1'b0, 32'h0);
    set_fetch(2, 1'b0, 32'h0);
    set_fetch(3, 1'b1, 32'h4);
    set_prog(1'b0, 10'h0, 32'h0);

    // Reset: outputs cleared, stall forced low even with ce high.
    cyc();
    cyc();
    chk("rst_stall_u3", 64'(f3.stallreq), 64'd0);
    chk("rst_inst_u0", 64'(f0.inst), 64'd0);
    chk("rst_valid_u0", 64'(f0.inst_valid), 64'd0);
    chk("rst_err_u2", 64'(f2.inst_err), 64'd0);
    chk("rst_fc_u3", 64'(f3.fetch_count), 64'd0);
    set_fetch(3, 1'b0, 32'h0);
    rst = 1'b1;

    // Load words 0..15 into all stores.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = (i < 4) ? 32'(32'h11 * (i + 1)) : 32'(32'h100 + i);
      cyc();
      set_prog(1'b1, 10'(i), ref_mem[i]);
    end
    cyc();
    set_prog(1'b0, 10'h0, 32'h0);

    // Zero wait states: back-to-back fetches, one per cycle.
    for (int i = 0; i < 4; i++) begin
      cyc();
      set_fetch(0, 1'b1, 32'(4 * i));
      push_exp(0, exp_of(32'(4 * i)));
      #1 chk($sformatf("u0_stall_b2b%0d", i), 64'(f0.stallreq), 64'd0);
    end
    cyc();
    set_fetch(0, 1'b0, 32'h0);
    chk("u0_fc_after_b2b", 64'(f0.fetch_count), 64'd4);

    // Misaligned and out-of-range fetches.
    cyc(); set_fetch(0, 1'b1, 32'h2);    push_exp(0, exp_of(32'h2));
    cyc(); set_fetch(0, 1'b1, 32'h1000); push_exp(0, exp_of(32'h1000));
    cyc(); set_fetch(0, 1'b0, 32'h0);

    // Same-cycle write and fetch of word 5 returns the old word.
    cyc();
    set_fetch(0, 1'b1, 32'd20);
    set_prog(1'b1, 10'd5, 32'hDEADBEEF);
    push_exp(0, exp_of(32'd20));
    ref_mem[5] = 32'hDEADBEEF;
    cyc();
    set_prog(1'b0, 10'h0, 32'h0);
    push_exp(0, exp_of(32'd20));
    cyc();
    set_fetch(0, 1'b0, 32'h0);
    chk("u0_fc_total", 64'(f0.fetch_count), 64'd8);

    // Two wait states: stall 1,1,0 then response.
    fetch_ws(2, 2, 32'h4, "u2_f1");
    chk("u2_fc_1", 64'(get_fc(2)), 64'd1);

    // pc moved during WAIT is ignored.
    cyc(); set_fetch(2, 1'b1, 32'h4); push_exp(2, exp_of(32'h4));
    cyc(); set_fetch(2, 1'b1, 32'h8);
    cyc();
    cyc(); set_fetch(2, 1'b0, 32'h0);
    chk("u2_fc_2", 64'(get_fc(2)), 64'd2);

    // Abort with ce low while cnt==1: no response, back to IDLE.
    cyc(); set_fetch(2, 1'b1, 32'h8);
    cyc(); set_fetch(2, 1'b0, 32'h0);
    cyc();
    #1 chk("u2_stall_ce0", 64'(f2.stallreq), 64'd0);
    cyc();
    chk("u2_fc_abort", 64'(get_fc(2)), 64'd2);
    fetch_ws(2, 2, 32'hC, "u2_after_abort");
    chk("u2_fc_3", 64'(get_fc(2)), 64'd3);

    // ce drops in the cycle cnt reaches 0: no accept.
    cyc(); set_fetch(2, 1'b1, 32'h0);
    cyc();
    cyc(); set_fetch(2, 1'b0, 32'h0);
    cyc();
    cyc();
    chk("u2_fc_late_drop", 64'(get_fc(2)), 64'd3);

    // Three wait states, then reset in the middle of a fetch.
    fetch_ws(3, 3, 32'h8, "u3_f1");
    chk("u3_fc_1", 64'(get_fc(3)), 64'd1);
    cyc(); set_fetch(3, 1'b1, 32'h4);
    cyc();
    cyc();
    rst = 1'b0;
    set_prog(1'b1, 10'd6, 32'h0BAD0BAD);
    #1 chk("u3_stall_in_rst", 64'(f3.stallreq), 64'd0);
    cyc();
    chk("u3_fc_rst", 64'(f3.fetch_count), 64'd0);
    chk("u3_inst_rst", 64'(f3.inst), 64'd0);
    chk("u3_valid_rst", 64'(f3.inst_valid), 64'd0);
    chk("u0_fc_rst", 64'(f0.fetch_count), 64'd0);
    set_fetch(3, 1'b0, 32'h0);
    set_prog(1'b0, 10'h0, 32'h0);
    cyc();
    rst = 1'b1;

    // Store preserved across reset; write during reset ignored.
    fetch_ws(3, 3, 32'd20, "u3_post_rst");
    fetch_ws(3, 3, 32'd24, "u3_rst_write");
    chk("u3_fc_post", 64'(get_fc(3)), 64'd2);

    repeat (4) cyc();
    chk("q0_drain", 64'(q0.size()), 64'd0);
    chk("q2_drain", 64'(q2.size()), 64'd0);
    chk("q3_drain", 64'(q3.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-fetch responder at the memory end of the fetch interface. Accepts the fetch address and chip enable driven by the PC stage and returns the addressed 32-bit instruction word from an internal word-addressed program store. It inserts a programmable number of wait states per fetch and requests a pipeline stall while a fetch is outstanding. A side port loads the program store.

## Interface
- ADDR_WIDTH, 10: word-index width; store depth = 2^ADDR_WIDTH words.
- WAIT_STATES, 0: extra cycles per fetch, legal range 0..15.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 sampled at a rising edge resets the block).
- ce  in  1  fetch enable from PC stage.
- pc  in  32  byte fetch address.
- stallreq  out  1  combinational; 1 = hold PC/fetch (feeds stall[0] via the stall controller).
- inst  out  32  registered instruction word.
- inst_valid  out  1  registered; 1 for exactly the cycle after a fetch is accepted.
- inst_err  out  1  registered; qualifies inst_valid; misaligned or out-of-range fetch.
- prog_we  in  1  program-store write enable.
- prog_addr  in  ADDR_WIDTH  program-store word index.
- prog_wdata  in  32  program-store write data.
- fetch_count  out  32  registered count of accepted fetches.

## Operation
- Word index = pc[ADDR_WIDTH+1:2]. Out of range: any of pc[31:ADDR_WIDTH+2] nonzero. Misaligned: pc[1:0] != 0.
- accept = ce & ~stallreq & rst. On an accepted fetch: inst <= store[index] (or 32'h0 on error), inst_err <= error, inst_valid <= 1, fetch_count += 1 (wraps 2^32-1 -> 0). Otherwise inst_valid <= 0, inst_err <= 0, inst holds.
- State machine, states IDLE and WAIT; 4-bit counter cnt.
  - IDLE: stallreq = ce & (WAIT_STATES != 0). If ce==1 and WAIT_STATES==0: accept, stay IDLE. If ce==1 and WAIT_STATES>0: latch pc into req_addr, cnt <= WAIT_STATES-1, go WAIT. If ce==0: stay IDLE.
  - WAIT: stallreq = ce & (cnt != 0). ce==0: abort, go IDLE, no response. cnt != 0: cnt -= 1. cnt == 0: accept using req_addr (not live pc), go IDLE.
- Result: each fetch occupies WAIT_STATES+1 cycles; back-to-back fetches at WAIT_STATES=0 sustain one per cycle.
- pc changes while in WAIT are ignored; req_addr is used.
- Program port: when prog_we==1 and rst==1, store[prog_addr] <= prog_wdata at the edge. A fetch reading the same word in the same cycle returns the old data. Writes ignored while rst==0. Store contents are not cleared by reset.

## Timing
- Reset (rst==0 at edge): state IDLE, cnt 0, inst 32'h0, inst_valid 0, inst_err 0, fetch_count 0. stallreq forced 0 while rst==0.
- Latency: inst/inst_valid appear 1 cycle after the accepting edge. With WAIT_STATES=N, the response appears N+1 cycles after the first cycle ce==1 is presented in IDLE.
- stallreq is combinational from ce, state and cnt. There is no path from pc to stallreq.
- Reset mid-WAIT: outstanding fetch dropped, no inst_valid.
- ce falling in the same cycle the counter reaches 0: no accept, no response.

## Test plan
- WAIT_STATES=0, store[0..3]=32'h11,22,33,44. Hold rst=0 for 2 cycles, then ce=1 with pc=0,4,8,12 on consecutive cycles -> inst_valid high for 4 consecutive cycles with inst 11,22,33,44; stallreq stays 0; fetch_count=4.
- WAIT_STATES=2, pc=4 held with ce=1 -> stallreq=1,1,0 on cycles 0..2; inst=32'h22 with inst_valid on cycle 3; fetch_count=1.
- WAIT_STATES=2, pc changed to 8 during WAIT -> response is still store[1]. Then ce=0 at cnt==1 -> next request produces no inst_valid, block returns to IDLE, fetch_count unchanged.
- Fetches to pc=32'h2 and pc=32'h1000 (ADDR_WIDTH=10) -> inst=32'h0 with inst_valid=1 and inst_err=1.
- prog_we=1 with prog_addr=5, wdata=32'hDEADBEEF, while fetching pc=20 in the same cycle -> old word returned. The next fetch of pc=20 returns 32'hDEADBEEF.
- rst asserted during WAIT with WAIT_STATES=3 -> all outputs reset next edge, stallreq=0 immediately, store contents preserved.
